// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC owner and 2-entry fetch buffer feeding decode over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int          Nloc     = 64,
  parameter int          Dbits    = 32,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [$clog2(Nloc)-1:0] imem_addr,
  input  logic [Dbits-1:0]        imem_instr,
  input  logic                    redirect,
  input  logic [Dbits-1:0]        redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [Dbits-1:0]        out_instr,
  output logic [Dbits-1:0]        out_pc,
  output logic [Dbits-1:0]        out_pc_plus4
);

  localparam int c_AW = $clog2(Nloc);

  logic [Dbits-1:0] r_fetch_pc;
  logic [Dbits-1:0] r_instr [2];
  logic [Dbits-1:0] r_pc    [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;

  logic             w_pop;
  logic             w_push;
  logic [Dbits-1:0] w_redirect_target;

  assign imem_addr         = r_fetch_pc[c_AW+1:2];
  assign out_valid         = (r_count != 2'd0);
  assign w_pop             = out_valid & out_ready;
  // A full buffer may only accept a new word when the head leaves this cycle.
  assign w_push            = ~redirect & ((r_count < 2'd2) | w_pop);
  assign w_redirect_target = redirect_pc & ~Dbits'(3);

  assign out_instr    = r_instr[r_rd_ptr];
  assign out_pc       = r_pc[r_rd_ptr];
  assign out_pc_plus4 = r_pc[r_rd_ptr] + Dbits'(4);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc <= Dbits'(RESET_PC);
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (redirect) begin
      // Flush; any concurrent pop is simply absorbed by the flush.
      r_fetch_pc <= w_redirect_target;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr] <= imem_instr;
        r_pc[r_wr_ptr]    <= r_fetch_pc;
        r_wr_ptr          <= ~r_wr_ptr;
        r_fetch_pc        <= r_fetch_pc + Dbits'(4);
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire
